eee_rx_lpi_ctrl: RTL and testbench

//  Clause 36 EEE receive-LPI sequencer. Tracks the link through sleep, quiet,

---
 rtl/pcs_pkg.sv | 24 ++
 rtl/lpi_shared_timer.sv | 36 +++
 rtl/eee_rx_lpi_ctrl.sv | 157 +++++++++++++++
 tb/tb_eee_rx_lpi_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared types and default timing constants for the EEE receive-LPI sequencer.
package pcs_pkg;

    typedef enum logic [2:0] {
        LPI_RX_ACTIVE    = 3'd0,
        LPI_RX_SLEEP     = 3'd1,
        LPI_RX_QUIET     = 3'd2,
        LPI_RX_WAKE      = 3'd3,
        LPI_RX_WTF       = 3'd4,
        LPI_RX_LINK_FAIL = 3'd5
    } lpi_rx_state_t;

    // Phase durations in clk cycles at 125 MHz.
    localparam int unsigned LPI_TQ_CYCLES = 625;        // 5 us quiet timeout
    localparam int unsigned LPI_TW_CYCLES = 125;        // 1 us wake timer
    localparam int unsigned LPI_WF_CYCLES = 6_250_000;  // 50 ms wake-fault timer
    localparam int unsigned LPI_CNT_W     = 23;

    // States that own the shared timer while occupied.
    function automatic logic lpi_is_timed(lpi_rx_state_t s);
        return (s == LPI_RX_QUIET) || (s == LPI_RX_WAKE) || (s == LPI_RX_WTF);
    endfunction

endpackage

// File: rtl/lpi_shared_timer.sv
// Reloadable down-counter shared by all LPI phase timers.
module lpi_shared_timer #(
    parameter int unsigned CNT_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/eee_rx_lpi_ctrl.sv
// EEE receive-LPI sequencer: walks the link through sleep, quiet, wake and
// wake-fault phases, timing each with one shared down-counter.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  ACTIVE     | normal traffic, waiting for /LI/ with EEE enabled
//  SLEEP      | /LI/ seen, waiting for the line to go quiet
//  QUIET      | line quiet, PMA may power down; TQ running, refresh reloads
//  WAKE       | wake signalled, waiting for /I/ within TW
//  WTF        | wake timed out, waiting for /I/ within WF
//  LINK_FAIL  | TQ or WF expired; held until fail_clr
module eee_rx_lpi_ctrl
    import pcs_pkg::*;
#(
    parameter int unsigned TQ_CYCLES = LPI_TQ_CYCLES,
    parameter int unsigned TW_CYCLES = LPI_TW_CYCLES,
    parameter int unsigned WF_CYCLES = LPI_WF_CYCLES,
    parameter int unsigned CNT_W     = LPI_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lpi_en,
    input  logic        sleep_det,
    input  logic        quiet_det,
    input  logic        wake_det,
    input  logic        idle_det,
    input  logic        fail_clr,
    output logic        rx_lpi_active,
    output logic        rx_quiet,
    output logic [2:0]  lpi_state,
    output logic        wake_done,
    output logic        wake_err,
    output logic        link_fail,
    output logic [15:0] wtf_count
);

    lpi_rx_state_t    state_q, state_d;
    logic             wake_done_q, wake_done_d;
    logic             wake_err_q, wake_err_d;
    logic             rx_lpi_active_q, rx_lpi_active_d;
    logic             rx_quiet_q, rx_quiet_d;
    logic             link_fail_q, link_fail_d;
    logic [15:0]      wtf_count_q, wtf_count_d;
    logic             refresh;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_expired;

    lpi_shared_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expired  (tmr_expired)
    );

    // Next-state and pulse decode; lpi_en drop outranks every other event
    // in the LPI phases, wake/idle outrank the timer expiring on the same cycle.
    always_comb begin
        state_d     = state_q;
        wake_done_d = 1'b0;
        wake_err_d  = 1'b0;
        wtf_count_d = wtf_count_q;
        refresh     = 1'b0;
        case (state_q)
            LPI_RX_ACTIVE: begin
                if (sleep_det && lpi_en) state_d = LPI_RX_SLEEP;
            end
            LPI_RX_SLEEP: begin
                if (!lpi_en)        state_d = LPI_RX_ACTIVE;
                else if (quiet_det) state_d = LPI_RX_QUIET;
                else if (idle_det)  state_d = LPI_RX_ACTIVE;
            end
            LPI_RX_QUIET: begin
                if (!lpi_en)          state_d = LPI_RX_ACTIVE;
                else if (wake_det)    state_d = LPI_RX_WAKE;
                else if (sleep_det)   refresh = 1'b1;
                else if (tmr_expired) state_d = LPI_RX_LINK_FAIL;
            end
            LPI_RX_WAKE: begin
                if (!lpi_en) begin
                    state_d = LPI_RX_ACTIVE;
                end else if (idle_det) begin
                    state_d     = LPI_RX_ACTIVE;
                    wake_done_d = 1'b1;
                end else if (tmr_expired) begin
                    state_d    = LPI_RX_WTF;
                    wake_err_d = 1'b1;
                    if (wtf_count_q != 16'hFFFF) wtf_count_d = wtf_count_q + 16'd1;
                end
            end
            LPI_RX_WTF: begin
                if (!lpi_en) begin
                    state_d = LPI_RX_ACTIVE;
                end else if (idle_det) begin
                    state_d     = LPI_RX_ACTIVE;
                    wake_done_d = 1'b1;
                end else if (tmr_expired) begin
                    state_d = LPI_RX_LINK_FAIL;
                end
            end
            LPI_RX_LINK_FAIL: begin
                if (fail_clr) state_d = LPI_RX_ACTIVE;
            end
            default: state_d = LPI_RX_ACTIVE;
        endcase

        rx_lpi_active_d = (state_d == LPI_RX_SLEEP) || (state_d == LPI_RX_QUIET) ||
                          (state_d == LPI_RX_WAKE)  || (state_d == LPI_RX_WTF);
        rx_quiet_d      = (state_d == LPI_RX_QUIET);
        link_fail_d     = (state_d == LPI_RX_LINK_FAIL);
    end

    // Timer reloads on entry or refresh and is pinned to zero outside timed
    // phases, so a fresh entry never sees a stale count.
    always_comb begin
        tmr_load = !lpi_is_timed(state_d) || (state_d != state_q) || refresh;
        case (state_d)
            LPI_RX_QUIET: tmr_load_val = CNT_W'(TQ_CYCLES - 1);
            LPI_RX_WAKE:  tmr_load_val = CNT_W'(TW_CYCLES - 1);
            LPI_RX_WTF:   tmr_load_val = CNT_W'(WF_CYCLES - 1);
            default:      tmr_load_val = '0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= LPI_RX_ACTIVE;
            wake_done_q     <= 1'b0;
            wake_err_q      <= 1'b0;
            rx_lpi_active_q <= 1'b0;
            rx_quiet_q      <= 1'b0;
            link_fail_q     <= 1'b0;
            wtf_count_q     <= 16'd0;
        end else begin
            state_q         <= state_d;
            wake_done_q     <= wake_done_d;
            wake_err_q      <= wake_err_d;
            rx_lpi_active_q <= rx_lpi_active_d;
            rx_quiet_q      <= rx_quiet_d;
            link_fail_q     <= link_fail_d;
            wtf_count_q     <= wtf_count_d;
        end
    end

    assign lpi_state     = state_q;
    assign rx_lpi_active = rx_lpi_active_q;
    assign rx_quiet      = rx_quiet_q;
    assign link_fail     = link_fail_q;
    assign wake_done     = wake_done_q;
    assign wake_err      = wake_err_q;
    assign wtf_count     = wtf_count_q;

endmodule

// File: tb/tb_eee_rx_lpi_ctrl.sv
// Bench for eee_rx_lpi_ctrl with short phase timers (TQ=8, TW=4, WF=16).
module tb_eee_rx_lpi_ctrl;
    import pcs_pkg::*;

    localparam int unsigned TQ = 8;
    localparam int unsigned TW = 4;
    localparam int unsigned WF = 16;
    localparam int unsigned CW = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lpi_en = 1'b0, sleep_det = 1'b0, quiet_det = 1'b0;
    logic        wake_det = 1'b0, idle_det = 1'b0, fail_clr = 1'b0;
    logic        rx_lpi_active, rx_quiet, wake_done, wake_err, link_fail;
    logic [2:0]  lpi_state;
    logic [15:0] wtf_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase plus number of cycles spent in it so far.
    lpi_rx_state_t m_state = LPI_RX_ACTIVE;
    int            m_occ   = 0;
    logic          m_done  = 1'b0;
    logic          m_err   = 1'b0;
    int            m_wtf   = 0;

    eee_rx_lpi_ctrl #(
        .TQ_CYCLES (TQ),
        .TW_CYCLES (TW),
        .WF_CYCLES (WF),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lpi_en        (lpi_en),
        .sleep_det     (sleep_det),
        .quiet_det     (quiet_det),
        .wake_det      (wake_det),
        .idle_det      (idle_det),
        .fail_clr      (fail_clr),
        .rx_lpi_active (rx_lpi_active),
        .rx_quiet      (rx_quiet),
        .lpi_state     (lpi_state),
        .wake_done     (wake_done),
        .wake_err      (wake_err),
        .link_fail     (link_fail),
        .wtf_count     (wtf_count)
    );

    always #5 clk = ~clk;

    logic [7:0]  obs_st;
    logic [23:0] obs_vec;
    assign obs_st  = {lpi_state, rx_lpi_active, rx_quiet, link_fail, wake_done, wake_err};
    assign obs_vec = {obs_st, wtf_count};

    // Output pattern implied by being in phase s with the given pulses.
    function automatic logic [7:0] st_vec(lpi_rx_state_t s, logic d, logic e);
        logic act;
        act = (s == LPI_RX_SLEEP) || (s == LPI_RX_QUIET) || (s == LPI_RX_WAKE) || (s == LPI_RX_WTF);
        return {s, act, s == LPI_RX_QUIET, s == LPI_RX_LINK_FAIL, d, e};
    endfunction

    function automatic logic [23:0] exp_vec();
        return {st_vec(m_state, m_done, m_err), m_wtf[15:0]};
    endfunction

    function automatic int phase_len(lpi_rx_state_t s);
        case (s)
            LPI_RX_QUIET: return TQ;
            LPI_RX_WAKE:  return TW;
            LPI_RX_WTF:   return WF;
            default:      return 0;
        endcase
    endfunction

    // One clock edge of the protocol rules, using the inputs held across it.
    task automatic model_step();
        lpi_rx_state_t nxt;
        logic          timeout, refresh;
        if (rst) begin
            m_state = LPI_RX_ACTIVE; m_occ = 0; m_done = 0; m_err = 0; m_wtf = 0;
            return;
        end
        m_done  = 0;
        m_err   = 0;
        timeout = (phase_len(m_state) != 0) && (m_occ == phase_len(m_state));
        refresh = 0;
        nxt     = m_state;
        case (m_state)
            LPI_RX_ACTIVE: if (sleep_det && lpi_en) nxt = LPI_RX_SLEEP;
            LPI_RX_SLEEP: begin
                if (!lpi_en) nxt = LPI_RX_ACTIVE;
                else if (quiet_det) nxt = LPI_RX_QUIET;
                else if (idle_det) nxt = LPI_RX_ACTIVE;
            end
            LPI_RX_QUIET: begin
                if (!lpi_en) nxt = LPI_RX_ACTIVE;
                else if (wake_det) nxt = LPI_RX_WAKE;
                else if (sleep_det) refresh = 1;
                else if (timeout) nxt = LPI_RX_LINK_FAIL;
            end
            LPI_RX_WAKE: begin
                if (!lpi_en) nxt = LPI_RX_ACTIVE;
                else if (idle_det) begin nxt = LPI_RX_ACTIVE; m_done = 1; end
                else if (timeout) begin
                    nxt = LPI_RX_WTF; m_err = 1;
                    m_wtf = (m_wtf >= 65535) ? 65535 : m_wtf + 1;
                end
            end
            LPI_RX_WTF: begin
                if (!lpi_en) nxt = LPI_RX_ACTIVE;
                else if (idle_det) begin nxt = LPI_RX_ACTIVE; m_done = 1; end
                else if (timeout) nxt = LPI_RX_LINK_FAIL;
            end
            default: if (fail_clr) nxt = LPI_RX_ACTIVE;
        endcase
        if (nxt != m_state || refresh) m_occ = 1;
        else m_occ = m_occ + 1;
        m_state = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic en, input logic sl, input logic qt,
                          input logic wk, input logic id, input logic fc);
        lpi_en = en; sleep_det = sl; quiet_det = qt; wake_det = wk; idle_det = id; fail_clr = fc;
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0);
        rst = 1; tick(); rst = 0;
    endtask

    // Leaves the DUT having just entered QUIET on the last edge.
    task automatic to_quiet();
        set_in(1, 1, 0, 0, 0, 0); tick();
        set_in(1, 0, 1, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0);
    endtask

    // Leaves the DUT having just entered WAKE on the last edge.
    task automatic to_wake();
        to_quiet();
        set_in(1, 0, 0, 1, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [7:0] e;
        do_reset();
        n_vec++;
        if (obs_vec !== 24'h0) begin
            n_err++; $display("FAIL reset: got %h expected %h", obs_vec, 24'h0);
        end
        set_in(0, 1, 0, 0, 0, 0); tick();
        e = st_vec(LPI_RX_ACTIVE, 0, 0);
        n_vec++;
        if (obs_st !== e) begin
            n_err++; $display("FAIL active_no_en: got %h expected %h", obs_st, e);
        end
    endtask

    task automatic test_wake();
        logic [7:0] e;
        do_reset();
        to_quiet();
        e = st_vec(LPI_RX_QUIET, 0, 0); n_vec++;
        if (obs_st !== e) begin n_err++; $display("FAIL t1_quiet: got %h expected %h", obs_st, e); end
        set_in(1, 0, 0, 1, 0, 0); tick();
        e = st_vec(LPI_RX_WAKE, 0, 0); n_vec++;
        if (obs_st !== e) begin n_err++; $display("FAIL t1_wake: got %h expected %h", obs_st, e); end
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 1, 0); tick();
        e = st_vec(LPI_RX_ACTIVE, 1, 0); n_vec++;
        if (obs_st !== e) begin n_err++; $display("FAIL t1_done: got %h expected %h", obs_st, e); end
        set_in(1, 0, 0, 0, 0, 0); tick();
        e = st_vec(LPI_RX_ACTIVE, 0, 0); n_vec++;
        if (obs_st !== e) begin n_err++; $display("FAIL t1_pulse_end: got %h expected %h", obs_st, e); end
    endtask

    task automatic test_wake_timeout();
        logic [23:0] e;
        do_reset();
        to_wake();
        for (int i = 1; i < int'(TW); i++) begin
            tick();
            e = {st_vec(LPI_RX_WAKE, 0, 0), 16'd0}; n_vec++;
            if (obs_vec !== e) begin n_err++; $display("FAIL t2_wake_k%0d: got %h expected %h", i, obs_vec, e); end
        end
        tick();
        e = {st_vec(LPI_RX_WTF, 0, 1), 16'd1}; n_vec++;
        if (obs_vec !== e) begin n_err++; $display("FAIL t2_wtf_entry: got %h expected %h", obs_vec, e); end
        for (int i = int'(TW) + 1; i < int'(TW + WF); i++) begin
            tick();
            e = {st_vec(LPI_RX_WTF, 0, 0), 16'd1}; n_vec++;
            if (obs_vec !== e) begin n_err++; $display("FAIL t2_wtf_k%0d: got %h expected %h", i, obs_vec, e); end
        end
        tick();
        e = {st_vec(LPI_RX_LINK_FAIL, 0, 0), 16'd1}; n_vec++;
        if (obs_vec !== e) begin n_err++; $display("FAIL t2_link_fail: got %h expected %h", obs_vec, e); end
        set_in(0, 1, 1, 1, 1, 0); tick();
        e = {st_vec(LPI_RX_LINK_FAIL, 0, 0), 16'd1}; n_vec++;
        if (obs_vec !== e) begin n_err++; $display("FAIL t5_lf_hold: got %h expected %h", obs_vec, e); end
        set_in(0, 0, 0, 0, 0, 1); tick();
        e = {st_vec(LPI_RX_ACTIVE, 0, 0), 16'd1}; n_vec++;
        if (obs_vec !== e) begin n_err++; $display("FAIL t5_fail_clr: got %h expected %h", obs_vec, e); end
    endtask

    task automatic test_refresh();
        logic [7:0] e;
        do_reset();
        to_quiet();
        for (int i = 1; i <= 13; i++) begin
            set_in(1, (i == 6), 0, 0, 0, 0);
            tick();
            e = st_vec(LPI_RX_QUIET, 0, 0); n_vec++;
            if (obs_st !== e) begin n_err++; $display("FAIL t3_quiet_k%0d: got %h expected %h", i, obs_st, e); end
        end
        set_in(1, 0, 0, 0, 0, 0); tick();
        e = st_vec(LPI_RX_LINK_FAIL, 0, 0); n_vec++;
        if (obs_st !== e) begin n_err++; $display("FAIL t3_link_fail: got %h expected %h", obs_st, e); end
    endtask

    task automatic test_simultaneous();
        logic [7:0]  e;
        logic [23:0] ev;
        do_reset();
        to_quiet();
        for (int i = 1; i < int'(TQ); i++) tick();
        set_in(1, 0, 0, 1, 0, 0); tick();
        e = st_vec(LPI_RX_WAKE, 0, 0); n_vec++;
        if (obs_st !== e) begin n_err++; $display("FAIL t4_wake_beats_tq: got %h expected %h", obs_st, e); end
        set_in(1, 0, 0, 0, 0, 0);
        for (int i = 1; i < int'(TW); i++) tick();
        set_in(1, 0, 0, 0, 1, 0); tick();
        ev = {st_vec(LPI_RX_ACTIVE, 1, 0), 16'd0}; n_vec++;
        if (obs_vec !== ev) begin n_err++; $display("FAIL t4_idle_beats_tw: got %h expected %h", obs_vec, ev); end
        set_in(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_lpi_disable();
        logic [23:0] e;
        do_reset();
        to_wake();
        for (int i = 0; i < int'(TW) + 3; i++) tick();
        set_in(0, 0, 0, 0, 1, 0); tick();
        e = {st_vec(LPI_RX_ACTIVE, 0, 0), 16'd1}; n_vec++;
        if (obs_vec !== e) begin n_err++; $display("FAIL t5_en_off_wtf: got %h expected %h", obs_vec, e); end
        set_in(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        logic [23:0] e;
        do_reset();
        @(negedge clk);
        dut.wtf_count_q = 16'hFFFE;
        m_wtf = 16'hFFFE;
        for (int n = 0; n < 2; n++) begin
            to_wake();
            for (int i = 0; i < int'(TW); i++) tick();
            e = {st_vec(LPI_RX_WTF, 0, 1), 16'hFFFF}; n_vec++;
            if (obs_vec !== e) begin n_err++; $display("FAIL t6_sat_%0d: got %h expected %h", n, obs_vec, e); end
            set_in(1, 0, 0, 0, 1, 0); tick();
            set_in(1, 0, 0, 0, 0, 0);
        end
        to_quiet();
        tick();
        rst = 1; tick(); rst = 0;
        n_vec++;
        if (obs_vec !== 24'h0) begin n_err++; $display("FAIL t6_rst_quiet: got %h expected %h", obs_vec, 24'h0); end
    endtask

    task automatic test_random();
        int dens;
        dens = 4;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) dens = $urandom_range(2, 20);
            rst = ($urandom_range(0, 499) == 0);
            set_in($urandom_range(0, 40) != 0,
                   $urandom_range(1, dens) == 1,
                   $urandom_range(1, dens) == 1,
                   $urandom_range(1, 2 * dens) == 1,
                   $urandom_range(1, 2 * dens) == 1,
                   $urandom_range(0, 9) == 0);
            tick();
            n_vec++;
            if (obs_vec !== exp_vec()) begin
                n_err++;
                $display("FAIL random_%0d: got %h expected %h", i, obs_vec, exp_vec());
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_wake();
        test_wake_timeout();
        test_refresh();
        test_simultaneous();
        test_lpi_disable();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
